pedestrian_light: RTL
=====================

Name: pedestrian_light

Overview:
- Pedestrian signal head paired with the car traffic light at the same crossing; forms the requesting end of the car light's start/night/lamp interface.
- Latches the push-button, drives `start` into the car light, and watches the car lamps.
- Grants WALK only while the car light shows red, after a clearance delay, followed by a blinking-WALK phase.
- Sits next to the car light in the crossing top level; both run on the same 50 MHz clock.

Parameters:
- WIDTH, 16: width of the phase timer and blink timer.
- CLEAR_TIME, 100: cycles of car red before WALK turns on (≥1).
- WALK_TIME, 1000: cycles of steady WALK (≥1).
- BLINK_TIME, 500: cycles of blinking WALK (≥1).
- BLINK_HALF, 50: cycles per blink half-period (≥1).
- All time values must fit in WIDTH bits.

Ports:
- clk50m  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- button  in  1  pedestrian request, level, already synchronous to clk50m.
- night  in  1  night mode; same signal that feeds the car light.
- car_red  in  1  red lamp of the car light.
- car_yellow  in  1  yellow lamp of the car light (monitor only).
- car_green  in  1  green lamp of the car light (monitor only).
- start  out  1  request to the car light to run its cycle.
- walk  out  1  green pedestrian lamp.
- dont_walk  out  1  red pedestrian lamp.
- wait_lamp  out  1  "signal coming" indicator.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, pending=0, timers=0.
  - Outputs during and after reset: start=0, walk=0, dont_walk=1, wait_lamp=0.
  - Reset asserted mid-operation aborts any phase within one cycle.
- Registered FSM; outputs decode from the current state. States:
  - DARK: all outputs 0.
    - night=0 → IDLE.
  - IDLE: dont_walk=1.
    - (button|pending)=1 → REQUEST.
  - REQUEST: dont_walk=1, wait_lamp=1.
    - start=1 while car_red=0; start is held (level, not a pulse) until car_red is seen.
    - car_red=1 → CLEARANCE; load the timer with CLEAR_TIME-1. If car_red is already 1 on entry, start is never raised.
  - CLEARANCE: dont_walk=1, wait_lamp=1.
    - Timer==0 → WALK; load WALK_TIME-1.
  - WALK: walk=1.
    - Timer==0 → WALK_BLINK; load BLINK_TIME-1; blink phase=on; load blink timer with BLINK_HALF-1.
  - WALK_BLINK: walk=blink phase.
    - Blink timer==0 → toggle phase, reload BLINK_HALF-1.
    - Phase timer==0 → STOP.
  - STOP: dont_walk=1.
    - car_red=0 → IDLE. This forbids reusing the same red interval.
- Phase durations:
  - Timers count down to 0 and hold.
  - CLEARANCE, WALK and WALK_BLINK each last exactly CLEAR_TIME, WALK_TIME and BLINK_TIME cycles respectively.
- Safety gate:
  - walk = (decoded walk) & car_red, so walk is never 1 in a cycle with car_red=0.
  - dont_walk = ~walk in all states except DARK.
  - car_red falling during CLEARANCE, WALK or WALK_BLINK → STOP on the next edge (early abort).
- Pending request:
  - button=1 in any state other than IDLE, REQUEST or DARK sets pending.
  - pending clears on entry to REQUEST.
  - wait_lamp = (state==REQUEST | state==CLEARANCE | pending), forced to 0 in DARK.
- Night:
  - night=1 → DARK on the next edge from any state; pending is cleared.
  - start, walk, dont_walk and wait_lamp all drop to 0 one cycle later.
  - night has priority over button, timer expiry and car_red events in the same cycle.
- Simultaneous events:
  - button held continuously in IDLE causes one request; after STOP it re-requests only through pending.
  - Timer expiry together with a car_red fall → STOP.
- car_yellow and car_green are unused by the FSM.

Test Plan:
Bench parameters: CLEAR_TIME=4, WALK_TIME=10, BLINK_TIME=8, BLINK_HALF=2.
1. Reset, then hold night=0 and car_red=0 for 5 cycles → dont_walk=1, walk=0, start=0, wait_lamp=0.
2. Pulse button for 1 cycle, then model car_red=1 six cycles after start rises:
   - start=1 for exactly 6 cycles, then 0.
   - walk rises 4 cycles after car_red rises and stays 1 for 10 cycles.
   - walk then follows the pattern 1,1,0,0,1,1,0,0.
   - dont_walk=1 after that.
   - IDLE is re-entered only after car_red falls.
3. Same as 2, but drop car_red on WALK cycle 3 → walk=0 in that same cycle, dont_walk=1, state STOP on the next edge.
4. Press button during WALK → wait_lamp=1 stays on through STOP; after car_red falls, REQUEST is re-entered and start rises again.
5. Assert night during WALK_BLINK → all outputs 0 from the next cycle on and pending cleared; release night → IDLE with dont_walk=1.
6. Assert rst_n=0 for 1 cycle during CLEARANCE → on the next edge walk=0, dont_walk=1, start=0, wait_lamp=0, and no WALK follows without a new button press.

Source files
------------

// File: rtl/pedestrian_light_if.sv
// Crossing-side bundle between the pedestrian head, the car light and the push-button.
// The pedestrian head is the slave; the crossing top level (or a bench) is the master.
interface pedestrian_light_if;
    logic button;
    logic night;
    logic car_red;
    logic car_yellow;
    logic car_green;
    logic start;
    logic walk;
    logic dont_walk;
    logic wait_lamp;

    modport master (
        output button, night, car_red, car_yellow, car_green,
        input  start, walk, dont_walk, wait_lamp
    );

    modport slave (
        input  button, night, car_red, car_yellow, car_green,
        output start, walk, dont_walk, wait_lamp
    );
endinterface

// File: rtl/pedestrian_light.sv
// Pedestrian signal head: latches requests, asks the car light for red, and grants
// WALK / blinking WALK only while the car red lamp is actually lit.
module pedestrian_light #(
    parameter int WIDTH      = 16,
    parameter int CLEAR_TIME = 100,
    parameter int WALK_TIME  = 1000,
    parameter int BLINK_TIME = 500,
    parameter int BLINK_HALF = 50
) (
    input  logic               clk50m,
    input  logic               rst_n,
    pedestrian_light_if.slave  bus
);
    typedef enum logic [2:0] {
        S_DARK, S_IDLE, S_REQUEST, S_CLEARANCE, S_WALK, S_WALK_BLINK, S_STOP
    } state_t;

    localparam logic [WIDTH-1:0] CLEAR_LD = WIDTH'(CLEAR_TIME - 1);
    localparam logic [WIDTH-1:0] WALK_LD  = WIDTH'(WALK_TIME - 1);
    localparam logic [WIDTH-1:0] BLINK_LD = WIDTH'(BLINK_TIME - 1);
    localparam logic [WIDTH-1:0] HALF_LD  = WIDTH'(BLINK_HALF - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] blink_q, blink_d;
    logic             phase_q, phase_d;
    logic             walk_dec_q, dark_q, req_q, wait_q;

    logic unused_lamps;
    assign unused_lamps = ^{bus.car_yellow, bus.car_green};

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        blink_d   = blink_q;
        phase_d   = phase_q;
        if (bus.night) begin
            state_d   = S_DARK;
            pending_d = 1'b0;
        end else begin
            if (bus.button && (state_q == S_CLEARANCE || state_q == S_WALK ||
                               state_q == S_WALK_BLINK || state_q == S_STOP))
                pending_d = 1'b1;
            case (state_q)
                S_DARK: state_d = S_IDLE;
                S_IDLE: begin
                    if (bus.button || pending_q) begin
                        state_d   = S_REQUEST;
                        pending_d = 1'b0;
                    end
                end
                S_REQUEST: begin
                    if (bus.car_red) begin
                        state_d = S_CLEARANCE;
                        timer_d = CLEAR_LD;
                    end
                end
                S_CLEARANCE: begin
                    if (!bus.car_red) begin
                        state_d = S_STOP;
                    end else if (timer_q == '0) begin
                        state_d = S_WALK;
                        timer_d = WALK_LD;
                    end else begin
                        timer_d = timer_q - ONE;
                    end
                end
                S_WALK: begin
                    if (!bus.car_red) begin
                        state_d = S_STOP;
                    end else if (timer_q == '0) begin
                        state_d = S_WALK_BLINK;
                        timer_d = BLINK_LD;
                        phase_d = 1'b1;
                        blink_d = HALF_LD;
                    end else begin
                        timer_d = timer_q - ONE;
                    end
                end
                S_WALK_BLINK: begin
                    if (!bus.car_red || timer_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        timer_d = timer_q - ONE;
                        if (blink_q == '0) begin
                            phase_d = ~phase_q;
                            blink_d = HALF_LD;
                        end else begin
                            blink_d = blink_q - ONE;
                        end
                    end
                end
                // Wait for red to end so one red interval never serves two crossings
                S_STOP:  if (!bus.car_red) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50m) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            timer_q    <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            walk_dec_q <= 1'b0;
            dark_q     <= 1'b0;
            req_q      <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            walk_dec_q <= (state_d == S_WALK) || (state_d == S_WALK_BLINK && phase_d);
            dark_q     <= (state_d == S_DARK);
            req_q      <= (state_d == S_REQUEST);
            wait_q     <= (state_d != S_DARK) &&
                          (state_d == S_REQUEST || state_d == S_CLEARANCE || pending_d);
        end
    end

    // Lamp gating on the live car_red keeps WALK dark in any cycle the car red is off
    assign bus.walk      = walk_dec_q & bus.car_red;
    assign bus.dont_walk = ~dark_q & ~(walk_dec_q & bus.car_red);
    assign bus.start     = req_q & ~bus.car_red;
    assign bus.wait_lamp = wait_q;
endmodule
